regfile_param: RTL and testbench

//  Parametrised dual-write-port CPU register file; successor to the fixed 16x32 file.

---
 rtl/regfile_param.sv | 184 ++++++++++++++++++
 tb/tb_regfile_param.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// ---------------------------------------------------------------------------
// regfile_param
//
// Parametrised CPU register file with two combined read/write ports, dedicated
// CC and PC outputs, PC auto-increment, defined write-collision priority and a
// per-register busy scoreboard for multi-cycle (load) results.
//
// Configuration macro:
//   REGFILE_BYPASS_EN  - when defined, reads (data and busy, including the
//                        CC/PC outputs) see writes arriving on the same edge.
//                        The PC increment result is never forwarded.
//                        When undefined, every output reflects stored state.
//
// Ports:
//   i_clk        clock, all state updates on the rising edge
//   i_reset      synchronous active-high reset, dominates every other input
//   i_sel_a/b    read and write select for port A / port B
//   i_wr_a/b     write enable for port A / port B
//   i_reg_a/b    write data for port A / port B
//   i_pc_inc     advance PC by PC_STEP unless a port writes PC this cycle
//   i_lock       mark register i_lock_sel busy (result pending)
//   i_lock_sel   register to lock
//   o_reg_a/b    contents of i_sel_a / i_sel_b
//   o_reg_cc     contents of register CC_IDX
//   o_reg_pc     contents of register PC_IDX
//   o_busy_a/b   busy bit of i_sel_a / i_sel_b
//   o_collision  registered; high for one cycle after a same-index dual write
// ---------------------------------------------------------------------------
module regfile_param #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 4,
    parameter int CC_IDX  = (2**ADDR_W) - 2,
    parameter int PC_IDX  = (2**ADDR_W) - 1,
    parameter int PC_STEP = 1
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic [ADDR_W-1:0] i_sel_a,
    input  logic [ADDR_W-1:0] i_sel_b,
    input  logic              i_wr_a,
    input  logic              i_wr_b,
    input  logic [DATA_W-1:0] i_reg_a,
    input  logic [DATA_W-1:0] i_reg_b,
    input  logic              i_pc_inc,
    input  logic              i_lock,
    input  logic [ADDR_W-1:0] i_lock_sel,
    output logic [DATA_W-1:0] o_reg_a,
    output logic [DATA_W-1:0] o_reg_b,
    output logic [DATA_W-1:0] o_reg_cc,
    output logic [DATA_W-1:0] o_reg_pc,
    output logic              o_busy_a,
    output logic              o_busy_b,
    output logic              o_collision
);

    localparam int                DEPTH   = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] CC_SEL  = ADDR_W'(CC_IDX);
    localparam logic [ADDR_W-1:0] PC_SEL  = ADDR_W'(PC_IDX);
    localparam logic [DATA_W-1:0] PC_INCR = DATA_W'(PC_STEP);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic              collision_q;
    logic              collision_d;

    // ------------------------------------------------------------------
    // Write / lock decode
    //
    // wr_hit[k] is set when either port commits to register k this cycle,
    // and wr_val[k] carries the value that will actually land there. Port B
    // is decoded after port A so that on a same-index collision B's data
    // wins while the hit bit still records that a write occurred (which is
    // what clears the busy bit, even for the dropped port-A write).
    // ------------------------------------------------------------------
    logic [DEPTH-1:0]  wr_hit;
    logic [DATA_W-1:0] wr_val [DEPTH];
    logic [DEPTH-1:0]  lock_hit;

    always_comb begin : write_decode
        // NOTE: every combinational output gets a default before any
        // conditional assignment, so no path can leave it unassigned and
        // infer a latch; blocking '=' is used because later statements
        // must see earlier ones within the same evaluation.
        wr_hit   = '0;
        lock_hit = '0;
        for (int k = 0; k < DEPTH; k++) begin
            wr_val[k] = '0;
        end

        if (i_wr_a) begin
            wr_hit[i_sel_a] = 1'b1;
            wr_val[i_sel_a] = i_reg_a;
        end
        // Port B last: it overrides port A on a same-index collision.
        if (i_wr_b) begin
            wr_hit[i_sel_b] = 1'b1;
            wr_val[i_sel_b] = i_reg_b;
        end

        if (i_lock) begin
            lock_hit[i_lock_sel] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin : next_state
        for (int k = 0; k < DEPTH; k++) begin
            regs_d[k] = regs_q[k];
        end

        // PC increment wraps modulo 2**DATA_W; an explicit write to the PC
        // index is applied afterwards and discards the increment.
        if (i_pc_inc) begin
            regs_d[PC_SEL] = regs_q[PC_SEL] + PC_INCR;
        end

        for (int k = 0; k < DEPTH; k++) begin
            if (wr_hit[k]) begin
                regs_d[k] = wr_val[k];
            end
        end

        // A committed write retires the pending result; a lock in the same
        // cycle means a newer result is outstanding, so the lock wins.
        busy_d = lock_hit | (busy_q & ~wr_hit);

        collision_d = i_wr_a & i_wr_b & (i_sel_a == i_sel_b);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking '<=' only, so every
        // register samples values from before the edge. The storage array
        // is cleared on reset because software relies on all registers,
        // including PC and CC, reading zero after reset.
        if (i_reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs_q[k] <= '0;
            end
            busy_q      <= '0;
            collision_q <= 1'b0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                regs_q[k] <= regs_d[k];
            end
            busy_q      <= busy_d;
            collision_q <= collision_d;
        end
    end

    assign o_collision = collision_q;

    // ------------------------------------------------------------------
    // Read paths
    // ------------------------------------------------------------------
`ifdef REGFILE_BYPASS_EN
    // Forward same-cycle write data. The busy bit of a register being
    // written reads 0 unless it is simultaneously re-locked. The PC
    // increment is deliberately not forwarded, only explicit writes.
    assign o_reg_a  = wr_hit[i_sel_a] ? wr_val[i_sel_a] : regs_q[i_sel_a];
    assign o_reg_b  = wr_hit[i_sel_b] ? wr_val[i_sel_b] : regs_q[i_sel_b];
    assign o_reg_cc = wr_hit[CC_SEL]  ? wr_val[CC_SEL]  : regs_q[CC_SEL];
    assign o_reg_pc = wr_hit[PC_SEL]  ? wr_val[PC_SEL]  : regs_q[PC_SEL];
    assign o_busy_a = wr_hit[i_sel_a] ? lock_hit[i_sel_a] : busy_q[i_sel_a];
    assign o_busy_b = wr_hit[i_sel_b] ? lock_hit[i_sel_b] : busy_q[i_sel_b];
`else
    assign o_reg_a  = regs_q[i_sel_a];
    assign o_reg_b  = regs_q[i_sel_b];
    assign o_reg_cc = regs_q[CC_SEL];
    assign o_reg_pc = regs_q[PC_SEL];
    assign o_busy_a = busy_q[i_sel_a];
    assign o_busy_b = busy_q[i_sel_b];
`endif

endmodule

// File: tb/tb_regfile_param.sv
// ---------------------------------------------------------------------------
// tb_regfile_param
//
// Self-checking bench for regfile_param at default parameters (16 x 32).
// Expected values are pushed onto a queue when stimulus is driven and popped
// when the corresponding outputs are sampled. Works with and without
// REGFILE_BYPASS_EN defined.
// ---------------------------------------------------------------------------
module tb_regfile_param;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;
    localparam int CC     = 14;
    localparam int PC     = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] sel_a, sel_b, lock_sel;
    logic              wr_a, wr_b, pc_inc, lock;
    logic [DATA_W-1:0] reg_a, reg_b;
    logic [DATA_W-1:0] o_reg_a, o_reg_b, o_reg_cc, o_reg_pc;
    logic              o_busy_a, o_busy_b, o_collision;

    logic [31:0] sb [$];
    logic [31:0] e;
    int          n_tests = 0;
    int          n_fail  = 0;

    // Reference model used by the random traffic scenario.
    logic [31:0] mdl [DEPTH];
    logic [DEPTH-1:0] mbusy;

    always #5 clk = ~clk;

    regfile_param dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_sel_a     (sel_a),
        .i_sel_b     (sel_b),
        .i_wr_a      (wr_a),
        .i_wr_b      (wr_b),
        .i_reg_a     (reg_a),
        .i_reg_b     (reg_b),
        .i_pc_inc    (pc_inc),
        .i_lock      (lock),
        .i_lock_sel  (lock_sel),
        .o_reg_a     (o_reg_a),
        .o_reg_b     (o_reg_b),
        .o_reg_cc    (o_reg_cc),
        .o_reg_pc    (o_reg_pc),
        .o_busy_a    (o_busy_a),
        .o_busy_b    (o_busy_b),
        .o_collision (o_collision)
    );

    task automatic idle();
        reset  = 1'b0;
        wr_a   = 1'b0;
        wr_b   = 1'b0;
        pc_inc = 1'b0;
        lock   = 1'b0;
    endtask

    // One rising edge, then drop all strobes; outputs are sampled 1ns+ later.
    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        // Put some state in r3 (data + busy) first.
        wr_a = 1'b1; sel_a = 4'd3; reg_a = 32'h0000_0001; lock = 1'b1; lock_sel = 4'd3;
        step();
        // Reset together with a write, a collision, a lock and a PC increment.
        reset = 1'b1;
        wr_a = 1'b1; sel_a = 4'd3; reg_a = 32'hDEAD_BEEF;
        wr_b = 1'b1; sel_b = 4'd3; reg_b = 32'hCAFE_F00D;
        lock = 1'b1; lock_sel = 4'd3; pc_inc = 1'b1;
        sb.push_back(32'h0); sb.push_back(32'h0); sb.push_back(32'h0);
        sb.push_back(32'h0); sb.push_back(32'h0);
        step();
        sel_a = 4'd3;
        #1;
        e = sb.pop_front(); n_tests++;
        if (o_reg_a !== e) begin n_fail++; $display("FAIL reset_reg_a: got %h want %h", o_reg_a, e); end
        e = sb.pop_front(); n_tests++;
        if (o_busy_a !== e[0]) begin n_fail++; $display("FAIL reset_busy_a: got %b want %b", o_busy_a, e[0]); end
        e = sb.pop_front(); n_tests++;
        if (o_collision !== e[0]) begin n_fail++; $display("FAIL reset_collision: got %b want %b", o_collision, e[0]); end
        e = sb.pop_front(); n_tests++;
        if (o_reg_pc !== e) begin n_fail++; $display("FAIL reset_pc: got %h want %h", o_reg_pc, e); end
        e = sb.pop_front(); n_tests++;
        if (o_reg_cc !== e) begin n_fail++; $display("FAIL reset_cc: got %h want %h", o_reg_cc, e); end
    endtask

    task automatic test_dual_write();
        wr_a = 1'b1; sel_a = 4'd1; reg_a = 32'h11;
        wr_b = 1'b1; sel_b = 4'd2; reg_b = 32'h22;
        sb.push_back(32'h11); sb.push_back(32'h22); sb.push_back(32'h0);
        step();
        sel_a = 4'd1; sel_b = 4'd2;
        #1;
        e = sb.pop_front(); n_tests++;
        if (o_reg_a !== e) begin n_fail++; $display("FAIL dual_r1: got %h want %h", o_reg_a, e); end
        e = sb.pop_front(); n_tests++;
        if (o_reg_b !== e) begin n_fail++; $display("FAIL dual_r2: got %h want %h", o_reg_b, e); end
        e = sb.pop_front(); n_tests++;
        if (o_collision !== e[0]) begin n_fail++; $display("FAIL dual_collision: got %b want %b", o_collision, e[0]); end
    endtask

    task automatic test_collision();
        lock = 1'b1; lock_sel = 4'd5;
        step();
        wr_a = 1'b1; sel_a = 4'd5; reg_a = 32'hAAAA;
        wr_b = 1'b1; sel_b = 4'd5; reg_b = 32'h5555;
        sb.push_back(32'h5555); sb.push_back(32'h1); sb.push_back(32'h0);
        step();
        sel_a = 4'd5;
        #1;
        e = sb.pop_front(); n_tests++;
        if (o_reg_a !== e) begin n_fail++; $display("FAIL coll_r5: got %h want %h", o_reg_a, e); end
        e = sb.pop_front(); n_tests++;
        if (o_collision !== e[0]) begin n_fail++; $display("FAIL coll_flag_set: got %b want %b", o_collision, e[0]); end
        e = sb.pop_front(); n_tests++;
        if (o_busy_a !== e[0]) begin n_fail++; $display("FAIL coll_busy_clr: got %b want %b", o_busy_a, e[0]); end
        sb.push_back(32'h0); sb.push_back(32'h5555);
        step();
        #1;
        e = sb.pop_front(); n_tests++;
        if (o_collision !== e[0]) begin n_fail++; $display("FAIL coll_flag_clr: got %b want %b", o_collision, e[0]); end
        e = sb.pop_front(); n_tests++;
        if (o_reg_a !== e) begin n_fail++; $display("FAIL coll_r5_hold: got %h want %h", o_reg_a, e); end
    endtask

    task automatic test_pc();
        wr_a = 1'b1; sel_a = 4'(PC); reg_a = 32'hFFFF_FFFF;
        step();
        pc_inc = 1'b1;
        sb.push_back(32'h0000_0000);
        step();
        #1;
        e = sb.pop_front(); n_tests++;
        if (o_reg_pc !== e) begin n_fail++; $display("FAIL pc_wrap: got %h want %h", o_reg_pc, e); end
        pc_inc = 1'b1; wr_b = 1'b1; sel_b = 4'(PC); reg_b = 32'h100;
        sb.push_back(32'h100);
        step();
        #1;
        e = sb.pop_front(); n_tests++;
        if (o_reg_pc !== e) begin n_fail++; $display("FAIL pc_write_override: got %h want %h", o_reg_pc, e); end
        pc_inc = 1'b1;
        sb.push_back(32'h101);
        step();
        #1;
        e = sb.pop_front(); n_tests++;
        if (o_reg_pc !== e) begin n_fail++; $display("FAIL pc_inc: got %h want %h", o_reg_pc, e); end
        // Increment alongside a write to some other register.
        pc_inc = 1'b1; wr_a = 1'b1; sel_a = 4'd1; reg_a = 32'h1111;
        wr_b = 1'b1; sel_b = 4'(CC); reg_b = 32'hCC;
        sb.push_back(32'h102); sb.push_back(32'h1111); sb.push_back(32'hCC);
        step();
        sel_a = 4'd1;
        #1;
        e = sb.pop_front(); n_tests++;
        if (o_reg_pc !== e) begin n_fail++; $display("FAIL pc_inc_other_wr: got %h want %h", o_reg_pc, e); end
        e = sb.pop_front(); n_tests++;
        if (o_reg_a !== e) begin n_fail++; $display("FAIL pc_other_r1: got %h want %h", o_reg_a, e); end
        e = sb.pop_front(); n_tests++;
        if (o_reg_cc !== e) begin n_fail++; $display("FAIL cc_out: got %h want %h", o_reg_cc, e); end
    endtask

    task automatic test_scoreboard();
        lock = 1'b1; lock_sel = 4'd7;
        sb.push_back(32'h1);
        step();
        sel_a = 4'd7;
        #1;
        e = sb.pop_front(); n_tests++;
        if (o_busy_a !== e[0]) begin n_fail++; $display("FAIL sb_lock: got %b want %b", o_busy_a, e[0]); end
        wr_b = 1'b1; sel_b = 4'd7; reg_b = 32'h70;
        sb.push_back(32'h0);
        step();
        sel_a = 4'd7;
        #1;
        e = sb.pop_front(); n_tests++;
        if (o_busy_a !== e[0]) begin n_fail++; $display("FAIL sb_write_clr: got %b want %b", o_busy_a, e[0]); end
        lock = 1'b1; lock_sel = 4'd7; wr_a = 1'b1; sel_a = 4'd7; reg_a = 32'h77;
        sb.push_back(32'h1); sb.push_back(32'h77);
        step();
        sel_a = 4'd7;
        #1;
        e = sb.pop_front(); n_tests++;
        if (o_busy_a !== e[0]) begin n_fail++; $display("FAIL sb_lock_wins: got %b want %b", o_busy_a, e[0]); end
        e = sb.pop_front(); n_tests++;
        if (o_reg_a !== e) begin n_fail++; $display("FAIL sb_lock_data: got %h want %h", o_reg_a, e); end
        lock = 1'b1; lock_sel = 4'd7;
        sb.push_back(32'h1);
        step();
        #1;
        e = sb.pop_front(); n_tests++;
        if (o_busy_a !== e[0]) begin n_fail++; $display("FAIL sb_relock: got %b want %b", o_busy_a, e[0]); end
        // Lock r8 while r7 and r9 are written: only r8 ends up busy.
        lock = 1'b1; lock_sel = 4'd8;
        wr_a = 1'b1; sel_a = 4'd7; reg_a = 32'h7;
        wr_b = 1'b1; sel_b = 4'd9; reg_b = 32'h9;
        sb.push_back(32'h0); sb.push_back(32'h1);
        step();
        sel_a = 4'd7; sel_b = 4'd8;
        #1;
        e = sb.pop_front(); n_tests++;
        if (o_busy_a !== e[0]) begin n_fail++; $display("FAIL sb_r7_clr: got %b want %b", o_busy_a, e[0]); end
        e = sb.pop_front(); n_tests++;
        if (o_busy_b !== e[0]) begin n_fail++; $display("FAIL sb_r8_set: got %b want %b", o_busy_b, e[0]); end
    endtask

    // PC holds 0x102 on entry (left by test_pc), r6 holds 0.
    task automatic test_bypass();
        wr_a = 1'b1; sel_a = 4'd4; reg_a = 32'hAB;
        step();
        lock = 1'b1; lock_sel = 4'd4;
        step();
        // Same-cycle write of r4 with a PC increment in flight.
        wr_a = 1'b1; sel_a = 4'd4; reg_a = 32'h1234; sel_b = 4'd4; pc_inc = 1'b1;
`ifdef REGFILE_BYPASS_EN
        sb.push_back(32'h1234); sb.push_back(32'h0);
`else
        sb.push_back(32'hAB);   sb.push_back(32'h1);
`endif
        sb.push_back(32'h102);
        #1;
        e = sb.pop_front(); n_tests++;
        if (o_reg_a !== e) begin n_fail++; $display("FAIL byp_same_cycle: got %h want %h", o_reg_a, e); end
        e = sb.pop_front(); n_tests++;
        if (o_busy_b !== e[0]) begin n_fail++; $display("FAIL byp_busy: got %b want %b", o_busy_b, e[0]); end
        e = sb.pop_front(); n_tests++;
        if (o_reg_pc !== e) begin n_fail++; $display("FAIL byp_pc_inc_not_fwd: got %h want %h", o_reg_pc, e); end
        sb.push_back(32'h1234); sb.push_back(32'h103);
        step();
        sel_a = 4'd4;
        #1;
        e = sb.pop_front(); n_tests++;
        if (o_reg_a !== e) begin n_fail++; $display("FAIL byp_next_cycle: got %h want %h", o_reg_a, e); end
        e = sb.pop_front(); n_tests++;
        if (o_reg_pc !== e) begin n_fail++; $display("FAIL byp_pc_next: got %h want %h", o_reg_pc, e); end
        // Colliding write to r6 plus explicit PC write, sampled in the same cycle.
        wr_a = 1'b1; sel_a = 4'd6; reg_a = 32'h66A;
        wr_b = 1'b1; sel_b = 4'd6; reg_b = 32'h66B;
`ifdef REGFILE_BYPASS_EN
        sb.push_back(32'h66B);
`else
        sb.push_back(32'h0);
`endif
        #1;
        e = sb.pop_front(); n_tests++;
        if (o_reg_a !== e) begin n_fail++; $display("FAIL byp_collision: got %h want %h", o_reg_a, e); end
        sb.push_back(32'h66B);
        step();
        sel_a = 4'd6;
        #1;
        e = sb.pop_front(); n_tests++;
        if (o_reg_a !== e) begin n_fail++; $display("FAIL byp_collision_next: got %h want %h", o_reg_a, e); end
        wr_b = 1'b1; sel_b = 4'(PC); reg_b = 32'h500;
`ifdef REGFILE_BYPASS_EN
        sb.push_back(32'h500);
`else
        sb.push_back(32'h103);
`endif
        #1;
        e = sb.pop_front(); n_tests++;
        if (o_reg_pc !== e) begin n_fail++; $display("FAIL byp_pc_write: got %h want %h", o_reg_pc, e); end
        step();
    endtask

    task automatic test_random_traffic();
        logic [ADDR_W-1:0] ra, rb;
        reset = 1'b1;
        step();
        for (int k = 0; k < DEPTH; k++) mdl[k] = '0;
        mbusy = '0;
        for (int it = 0; it < 60; it++) begin
            wr_a     = ($urandom_range(0, 2) != 0);
            wr_b     = ($urandom_range(0, 2) != 0);
            sel_a    = 4'($urandom_range(0, 15));
            sel_b    = ($urandom_range(0, 3) == 0) ? sel_a : 4'($urandom_range(0, 15));
            reg_a    = $urandom;
            reg_b    = $urandom;
            pc_inc   = ($urandom_range(0, 1) != 0);
            lock     = ($urandom_range(0, 2) == 0);
            lock_sel = 4'($urandom_range(0, 15));
            if (pc_inc) mdl[PC] = mdl[PC] + 32'd1;
            if (wr_a) begin mdl[sel_a] = reg_a; mbusy[sel_a] = 1'b0; end
            if (wr_b) begin mdl[sel_b] = reg_b; mbusy[sel_b] = 1'b0; end
            if (lock) mbusy[lock_sel] = 1'b1;
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            sb.push_back(mdl[ra]);
            sb.push_back(mdl[rb]);
            sb.push_back({31'b0, mbusy[ra]});
            sb.push_back({31'b0, mbusy[rb]});
            sb.push_back(mdl[PC]);
            sb.push_back(mdl[CC]);
            sb.push_back({31'b0, wr_a & wr_b & (sel_a == sel_b)});
            step();
            sel_a = ra; sel_b = rb;
            #1;
            e = sb.pop_front(); n_tests++;
            if (o_reg_a !== e) begin n_fail++; $display("FAIL rnd%0d_reg_a: got %h want %h", it, o_reg_a, e); end
            e = sb.pop_front(); n_tests++;
            if (o_reg_b !== e) begin n_fail++; $display("FAIL rnd%0d_reg_b: got %h want %h", it, o_reg_b, e); end
            e = sb.pop_front(); n_tests++;
            if (o_busy_a !== e[0]) begin n_fail++; $display("FAIL rnd%0d_busy_a: got %b want %b", it, o_busy_a, e[0]); end
            e = sb.pop_front(); n_tests++;
            if (o_busy_b !== e[0]) begin n_fail++; $display("FAIL rnd%0d_busy_b: got %b want %b", it, o_busy_b, e[0]); end
            e = sb.pop_front(); n_tests++;
            if (o_reg_pc !== e) begin n_fail++; $display("FAIL rnd%0d_pc: got %h want %h", it, o_reg_pc, e); end
            e = sb.pop_front(); n_tests++;
            if (o_reg_cc !== e) begin n_fail++; $display("FAIL rnd%0d_cc: got %h want %h", it, o_reg_cc, e); end
            e = sb.pop_front(); n_tests++;
            if (o_collision !== e[0]) begin n_fail++; $display("FAIL rnd%0d_collision: got %b want %b", it, o_collision, e[0]); end
        end
    endtask

    initial begin
        idle();
        sel_a = '0; sel_b = '0; lock_sel = '0;
        reg_a = '0; reg_b = '0;
        test_reset();
        test_dual_write();
        test_collision();
        test_pc();
        test_scoreboard();
        test_bypass();
        test_random_traffic();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
